wb_regfile: RTL and testbench

- Write-back end of the pipeline. It consumes the write-back control triple RegWr / RegDst / MemtoReg that the stage-4 control decoder produces.
- It provides:
  - the MEM/WB pipeline latch;
  - the destination and data muxes;
  - the 32-entry general register file with two combinational read ports and internal write-to-read bypass;
  - a retired-instruction counter.
- The ID stage reads operands from it. The EX-stage forwarding unit observes its wb_* outputs.

---
 rtl/wb_regfile.sv | 98 +++++++++
 tb/tb_wb_regfile.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// Write-back stage: MEM/WB latch, destination/data select, 32-entry register
// file with two bypassed combinational read ports, and retired-instruction count.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic              in_RegWr,
  input  logic              in_RegDst,
  input  logic              in_MemtoReg,
  input  logic [ADDR_W-1:0] in_rt,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_mem_data,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic [31:0]       retire_cnt
);
  localparam int NREG = 1 << ADDR_W;

  typedef struct packed {
    logic              valid;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_lat_t;

  wb_lat_t           r_lat;
  wb_lat_t           w_nxt;
  logic [DATA_W-1:0] r_regs [0:NREG-1];
  logic [31:0]       r_retire_cnt;
  logic              w_retire;

  always_comb begin
    w_nxt.valid = in_valid;
    w_nxt.addr  = in_RegDst ? in_rd : in_rt;
    w_nxt.data  = in_MemtoReg ? in_mem_data : in_alu_result;
    w_nxt.we    = in_valid & in_RegWr & (w_nxt.addr != '0);
  end

  // Flush only kills the incoming slot; addr/data are left as-is since they
  // are meaningless once valid/we drop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lat <= '0;
    end else if (flush) begin
      r_lat.valid <= 1'b0;
      r_lat.we    <= 1'b0;
    end else if (!stall) begin
      r_lat <= w_nxt;
    end
  end

  // Entry 0 is never written; reads of address 0 are forced to zero below.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (r_lat.we && r_lat.addr != '0) begin
      r_regs[r_lat.addr] <= r_lat.data;
    end
  end

  // The WB entry leaves whenever the latch is not holding it.
  assign w_retire = r_lat.valid & (~stall | flush);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_retire_cnt <= '0;
    else if (w_retire) r_retire_cnt <= r_retire_cnt + 32'd1;
  end

  always_comb begin
    rs_data = r_regs[rs_addr];
    if (rs_addr == '0)                          rs_data = '0;
    else if (r_lat.we && rs_addr == r_lat.addr) rs_data = r_lat.data;
  end

  always_comb begin
    rt_data = r_regs[rt_addr];
    if (rt_addr == '0)                          rt_data = '0;
    else if (r_lat.we && rt_addr == r_lat.addr) rt_data = r_lat.data;
  end

  assign wb_valid   = r_lat.valid;
  assign wb_we      = r_lat.we;
  assign wb_addr    = r_lat.addr;
  assign wb_data    = r_lat.data;
  assign retire_cnt = r_retire_cnt;
endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: expected latch contents queued at drive
// time, popped at each edge; a small register/counter model backs the reads.
module tb_wb_regfile;
  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush;
  logic        in_valid, in_RegWr, in_RegDst, in_MemtoReg;
  logic [4:0]  in_rt, in_rd, rs_addr, rt_addr;
  logic [31:0] in_alu_result, in_mem_data;
  logic [31:0] rs_data, rt_data, wb_data, retire_cnt;
  logic        wb_valid, wb_we;
  logic [4:0]  wb_addr;

  wb_regfile #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_RegWr(in_RegWr), .in_RegDst(in_RegDst),
    .in_MemtoReg(in_MemtoReg), .in_rt(in_rt), .in_rd(in_rd),
    .in_alu_result(in_alu_result), .in_mem_data(in_mem_data),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        cur;
  logic [31:0] mdl_regs [0:31];
  logic [31:0] mdl_cnt;
  int          total = 0;
  int          bad   = 0;
  logic [31:0] cnt0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mrd(input logic [4:0] a);
    if (a == 5'd0)                 return 32'd0;
    if (cur.we && a == cur.addr)   return cur.data;
    return mdl_regs[a];
  endfunction

  task automatic mdl_reset();
    for (int i = 0; i < 32; i++) mdl_regs[i] = 32'd0;
    mdl_cnt = 32'd0;
    cur = '{valid: 1'b0, we: 1'b0, addr: 5'd0, data: 32'd0};
    sb_q.delete();
  endtask

  task automatic drive(input logic v, input logic rw, input logic dst, input logic m2r,
                       input logic [4:0] rt, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] mem);
    exp_t e;
    in_valid = v; in_RegWr = rw; in_RegDst = dst; in_MemtoReg = m2r;
    in_rt = rt; in_rd = rd; in_alu_result = alu; in_mem_data = mem;
    e.valid = v;
    e.addr  = dst ? rd : rt;
    e.data  = m2r ? mem : alu;
    e.we    = v & rw & (e.addr != 5'd0);
    sb_q.push_back(e);
  endtask

  task automatic nop();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0);
  endtask

  // Advance the model across one edge, then compare the DUT after the edge.
  task automatic tick();
    exp_t e;
    if (sb_q.size() > 0) e = sb_q.pop_front();
    else e = '{valid: 1'b0, we: 1'b0, addr: 5'd0, data: 32'd0};
    if (cur.we) mdl_regs[cur.addr] = cur.data;
    if (cur.valid && (!stall || flush)) mdl_cnt = mdl_cnt + 32'd1;
    if (flush) begin
      cur.valid = 1'b0;
      cur.we    = 1'b0;
    end else if (!stall) begin
      cur = e;
    end
    @(posedge clk); #1;
    chk("wb_valid", {31'd0, wb_valid}, {31'd0, cur.valid});
    chk("wb_we", {31'd0, wb_we}, {31'd0, cur.we});
    if (cur.valid) begin
      chk("wb_addr", {27'd0, wb_addr}, {27'd0, cur.addr});
      chk("wb_data", wb_data, cur.data);
    end
    chk("retire_cnt", retire_cnt, mdl_cnt);
  endtask

  task automatic rd_chk(input string tag, input logic [4:0] a, input logic [4:0] b);
    rs_addr = a; rt_addr = b; #1;
    chk({tag, "_rs"}, rs_data, mrd(a));
    chk({tag, "_rt"}, rt_data, mrd(b));
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    rs_addr = 5'd0; rt_addr = 5'd0;
    mdl_reset();
    nop(); sb_q.delete();
    #2;
    chk("rst_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_we", {31'd0, wb_we}, 32'd0);
    chk("rst_addr", {27'd0, wb_addr}, 32'd0);
    chk("rst_data", wb_data, 32'd0);
    chk("rst_cnt", retire_cnt, 32'd0);
    @(negedge clk); rst = 1'b0;

    // R-type to rd=5
    drive(1, 1, 1, 0, 5'd9, 5'd5, 32'h1234, 32'h0);
    tick();
    chk("rtype_we", {31'd0, wb_we}, 32'd1);
    chk("rtype_addr", {27'd0, wb_addr}, 32'd5);
    chk("rtype_data", wb_data, 32'h1234);
    nop(); tick();
    rs_addr = 5'd5; rt_addr = 5'd9; #1;
    chk("rtype_r5", rs_data, 32'h1234);
    chk("rtype_r9", rt_data, 32'h0);

    // load to rt=7, visible through bypass while wb_we=1
    drive(1, 1, 0, 1, 5'd7, 5'd2, 32'h1, 32'hDEADBEEF);
    tick();
    rt_addr = 5'd7; #1;
    chk("bypass_r7", rt_data, 32'hDEADBEEF);
    nop(); tick();
    rd_chk("load_after", 5'd7, 5'd7);

    // destination zero
    cnt0 = retire_cnt;
    drive(1, 1, 1, 0, 5'd3, 5'd0, 32'hFFFF, 32'h0);
    tick();
    chk("r0_we", {31'd0, wb_we}, 32'd0);
    rs_addr = 5'd0; #1;
    chk("r0_read", rs_data, 32'd0);
    nop(); tick();
    chk("r0_retire", retire_cnt, cnt0 + 32'd1);

    // stall holds, flush with stall retires held entry
    drive(1, 1, 0, 0, 5'd3, 5'd8, 32'h10, 32'h0);
    tick();
    cnt0 = retire_cnt;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 1, 0, 5'd12, 5'd13, 32'h99, 32'h0);
      tick();
      chk("stall_addr", {27'd0, wb_addr}, 32'd3);
      chk("stall_data", wb_data, 32'h10);
      chk("stall_cnt", retire_cnt, cnt0);
    end
    flush = 1'b1;
    drive(1, 1, 1, 0, 5'd12, 5'd13, 32'h99, 32'h0);
    tick();
    flush = 1'b0; stall = 1'b0;
    chk("flush_valid", {31'd0, wb_valid}, 32'd0);
    chk("flush_cnt", retire_cnt, cnt0 + 32'd1);
    rs_addr = 5'd3; #1;
    chk("flush_r3", rs_data, 32'h10);

    // async reset while a write to reg4 is pending
    drive(1, 1, 1, 0, 5'd0, 5'd4, 32'hAA, 32'h0);
    tick();
    nop(); tick();
    rs_addr = 5'd4; #1;
    chk("pre_r4", rs_data, 32'hAA);
    drive(1, 1, 1, 0, 5'd0, 5'd4, 32'h55, 32'h0);
    tick();
    in_valid = 1'b0;
    rst = 1'b1; #1;
    mdl_reset();
    chk("arst_we", {31'd0, wb_we}, 32'd0);
    chk("arst_valid", {31'd0, wb_valid}, 32'd0);
    chk("arst_data", wb_data, 32'd0);
    chk("arst_r4", rs_data, 32'd0);
    chk("arst_cnt", retire_cnt, 32'd0);
    @(negedge clk); rst = 1'b0;
    rd_chk("post_rst", 5'd4, 5'd7);

    // counter wrap, then a store that writes nothing
    drive(1, 1, 1, 0, 5'd0, 5'd6, 32'h66, 32'h0);
    tick();
    nop(); tick();
    @(negedge clk);
    dut.r_retire_cnt = 32'hFFFFFFFF;
    mdl_cnt = 32'hFFFFFFFF;
    drive(1, 1, 1, 0, 5'd0, 5'd1, 32'h11, 32'h0);
    tick();
    drive(1, 0, 0, 0, 5'd6, 5'd6, 32'h77, 32'h77);
    tick();
    chk("wrap_cnt", retire_cnt, 32'd0);
    nop(); tick();
    chk("store_cnt", retire_cnt, 32'd1);
    rs_addr = 5'd6; #1;
    chk("store_r6", rs_data, 32'h66);

    // random mix with stall/flush, checked against the model
    for (int i = 0; i < 60; i++) begin
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 7) == 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            $urandom, $urandom);
      tick();
      rd_chk("rand", 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    stall = 1'b0; flush = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
